// File: rtl/cv32e40p_div_pkg.sv
// Shared types and constants for the serial-divider issue path.
package cv32e40p_div_pkg;

  typedef enum logic [1:0] {
    DIV_UDIV = 2'd0,
    DIV_DIV  = 2'd1,
    DIV_UREM = 2'd2,
    DIV_REM  = 2'd3
  } div_opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } div_issue_state_e;

  // Leading-zero count reported when the shifted divisor operand is all zero.
  localparam int unsigned C_DIV_LZC_ZERO = 31;

endpackage

// File: rtl/cv32e40p_div_lzc.sv
// Combinational leading-zero counter with an all-zero flag; cnt_o is 0 when zero_o is set.
module cv32e40p_div_lzc #(
  parameter int unsigned C_WIDTH = 32,
  localparam int unsigned C_CNT_W = $clog2(C_WIDTH)
) (
  input  logic [C_WIDTH-1:0] in_i,
  output logic [C_CNT_W-1:0] cnt_o,
  output logic               zero_o
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < C_WIDTH; i++) begin
      if (in_i[i]) cnt_o = C_CNT_W'(C_WIDTH - 1 - i);
    end
  end

  assign zero_o = ~|in_i;

endmodule

// File: rtl/cv32e40p_alu_div_issue.sv
// Initiator-side controller for the serial divider: accepts one div/rem request,
// derives the divisor side fields, runs the divider handshake and returns the result.
module cv32e40p_alu_div_issue
  import cv32e40p_div_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 32,
  parameter int unsigned C_LOG_WIDTH = 6,
  parameter int unsigned C_CNT_WIDTH = 8
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   ReqVld_SI,
  output logic                   ReqRdy_SO,
  input  logic [C_WIDTH-1:0]     ReqOpA_DI,
  input  logic [C_WIDTH-1:0]     ReqOpB_DI,
  input  logic [1:0]             ReqOpCode_SI,
  output logic                   RspVld_SO,
  input  logic                   RspRdy_SI,
  output logic [C_WIDTH-1:0]     RspRes_DO,
  output logic [C_CNT_WIDTH-1:0] RspCycles_DO,
  output logic [C_WIDTH-1:0]     DivOpA_DO,
  output logic [C_WIDTH-1:0]     DivOpB_DO,
  output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
  output logic                   DivOpBIsZero_SO,
  output logic                   DivOpBSign_SO,
  output logic [1:0]             DivOpCode_SO,
  output logic                   DivInVld_SO,
  output logic                   DivOutRdy_SO,
  input  logic                   DivOutVld_SI,
  input  logic [C_WIDTH-1:0]     DivRes_DI
);

  localparam int unsigned C_LZC_W = $clog2(C_WIDTH);

  div_issue_state_e       state_q, state_d;
  logic [C_WIDTH-1:0]     opa_q, opb_q, res_q;
  logic [C_LOG_WIDTH-1:0] shift_q, shift_d;
  logic                   iszero_q, sign_q;
  div_opcode_e            opcode_q;
  logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d, cycles_q;

  logic                   req_signed, b_sign, lzc_zero;
  logic [C_WIDTH-1:0]     b_eff;
  logic [C_LZC_W-1:0]     lzc_cnt;
  logic [C_LOG_WIDTH-1:0] lzc_val;

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + C_CNT_WIDTH'(1);
  endfunction

  // Negative signed divisors are inverted so the count measures magnitude bits.
  assign req_signed = ReqOpCode_SI[0];
  assign b_sign     = req_signed & ReqOpB_DI[C_WIDTH-1];
  assign b_eff      = b_sign ? ~ReqOpB_DI : ReqOpB_DI;

  cv32e40p_div_lzc #(
    .C_WIDTH(C_WIDTH)
  ) i_lzc (
    .in_i  (b_eff),
    .cnt_o (lzc_cnt),
    .zero_o(lzc_zero)
  );

  assign lzc_val = lzc_zero ? C_LOG_WIDTH'(C_DIV_LZC_ZERO) : C_LOG_WIDTH'(lzc_cnt);
  assign shift_d = lzc_val + (req_signed ? C_LOG_WIDTH'(0) : C_LOG_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ReqVld_SI)    state_d = ISSUE;
      ISSUE:                     state_d = WAIT;
      WAIT:    if (DivOutVld_SI) state_d = RESP;
      RESP:    if (RspRdy_SI)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // cnt_d in WAIT already includes the current cycle, so capturing it gives issue-to-OutVld distance.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)     cnt_d = '0;
    else if (state_q == WAIT) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      shift_q  <= '0;
      iszero_q <= 1'b0;
      sign_q   <= 1'b0;
      opcode_q <= DIV_UDIV;
      cnt_q    <= '0;
      res_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && ReqVld_SI) begin
        opa_q    <= ReqOpA_DI;
        opb_q    <= ReqOpB_DI;
        shift_q  <= shift_d;
        iszero_q <= (ReqOpB_DI == '0);
        sign_q   <= b_sign;
        opcode_q <= div_opcode_e'(ReqOpCode_SI);
      end
      if (state_q == WAIT && DivOutVld_SI) begin
        res_q    <= DivRes_DI;
        cycles_q <= cnt_d;
      end
    end
  end

  assign ReqRdy_SO       = (state_q == IDLE);
  assign DivInVld_SO     = (state_q == ISSUE);
  assign DivOutRdy_SO    = (state_q == WAIT);
  assign RspVld_SO       = (state_q == RESP);
  assign RspRes_DO       = res_q;
  assign RspCycles_DO    = cycles_q;
  assign DivOpA_DO       = opa_q;
  assign DivOpB_DO       = opb_q;
  assign DivOpBShift_DO  = shift_q;
  assign DivOpBIsZero_SO = iszero_q;
  assign DivOpBSign_SO   = sign_q;
  assign DivOpCode_SO    = opcode_q;

endmodule

// File: tb/tb_cv32e40p_alu_div_issue.sv
// Scoreboard bench for the divider issue controller with a behavioural stub divider.
module tb_cv32e40p_alu_div_issue;

  localparam int W  = 32;
  localparam int LW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ReqVld, ReqRdy, RspVld, RspRdy;
  logic [W-1:0]  ReqA, ReqB, RspRes, DivOpA, DivOpB, DivRes;
  logic [1:0]    ReqOp, DivOp;
  logic [CW-1:0] RspCycles;
  logic [LW-1:0] DivShift;
  logic          DivZero, DivSign, DivInVld, DivOutRdy, DivOutVld;

  always #5 clk = ~clk;

  cv32e40p_alu_div_issue #(.C_WIDTH(W), .C_LOG_WIDTH(LW), .C_CNT_WIDTH(CW)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .ReqVld_SI(ReqVld), .ReqRdy_SO(ReqRdy), .ReqOpA_DI(ReqA), .ReqOpB_DI(ReqB), .ReqOpCode_SI(ReqOp),
    .RspVld_SO(RspVld), .RspRdy_SI(RspRdy), .RspRes_DO(RspRes), .RspCycles_DO(RspCycles),
    .DivOpA_DO(DivOpA), .DivOpB_DO(DivOpB), .DivOpBShift_DO(DivShift), .DivOpBIsZero_SO(DivZero),
    .DivOpBSign_SO(DivSign), .DivOpCode_SO(DivOp), .DivInVld_SO(DivInVld), .DivOutRdy_SO(DivOutRdy),
    .DivOutVld_SI(DivOutVld), .DivRes_DI(DivRes)
  );

  typedef struct {
    logic [31:0] a, b, res;
    logic [1:0]  op;
    logic [7:0]  cyc;
    logic [5:0]  sh;
    logic        z, s;
  } txn_t;

  txn_t iss_q[$];
  txn_t rsp_q[$];
  int   lat_q[$];
  int   bp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (event not expected at t=%0t)", name, $time);
  endtask

  // RISC-V M-extension division semantics.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: return (b == 0) ? a : a % b;
      2'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
    endcase
  endfunction

  // Leading zeros of the magnitude via floor(log2); all-zero counts as 31.
  function automatic logic [5:0] ref_shift(input logic [31:0] b, input logic [1:0] op);
    logic [31:0] e;
    int lz;
    e = (op[0] && b[31]) ? ~b : b;
    if (e == 0) lz = 31;
    else lz = 32 - $clog2({32'd0, e} + 64'd1);
    return 6'(lz + (op[0] ? 0 : 1));
  endfunction

  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input int lat, input int bp);
    txn_t t;
    int n;
    t.a = a; t.b = b; t.op = op;
    t.res = ref_div(a, b, op);
    t.cyc = (lat > 255) ? 8'hFF : 8'(lat);
    t.sh  = ref_shift(b, op);
    t.z   = (b == 0);
    t.s   = op[0] & b[31];
    iss_q.push_back(t);
    rsp_q.push_back(t);
    lat_q.push_back(lat);
    bp_q.push_back(bp);
    @(posedge clk); #1;
    ReqVld = 1'b1; ReqA = a; ReqB = b; ReqOp = op;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ReqRdy && n < 2000);
    if (!ReqRdy) fail("req_timeout");
    @(posedge clk); #1;
    ReqVld = 1'b0; ReqA = $urandom; ReqB = $urandom; ReqOp = 2'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(rsp_q.size()), 0);
  endtask

  // Stub divider: OutVld rises a programmed number of cycles after InVld, holds until OutRdy.
  initial begin
    logic hs, inv, r, busy;
    int rem;
    logic [31:0] a, b;
    logic [1:0] op;
    DivOutVld = 1'b0; DivRes = '0; busy = 1'b0; rem = 0; a = '0; b = '0; op = '0;
    forever begin
      @(negedge clk);
      hs = DivOutVld && DivOutRdy;
      inv = DivInVld;
      r = rst_n;
      if (inv) begin a = DivOpA; b = DivOpB; op = DivOp; end
      @(posedge clk); #1;
      if (!r) begin
        busy = 1'b0;
        DivOutVld = 1'b0;
      end else begin
        if (hs) DivOutVld = 1'b0;
        if (inv) begin
          busy = 1'b1;
          rem = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        end
        if (busy) begin
          rem--;
          if (rem <= 0) begin
            busy = 1'b0;
            DivOutVld = 1'b1;
            DivRes = ref_div(a, b, op);
          end
        end
      end
    end
  end

  // Response sink: withholds RspRdy for the per-transaction backpressure count.
  initial begin
    logic in_rsp;
    int bp_left;
    RspRdy = 1'b1; in_rsp = 1'b0; bp_left = 0;
    forever begin
      @(posedge clk); #1;
      if (RspVld && !in_rsp) begin
        in_rsp = 1'b1;
        bp_left = (bp_q.size() > 0) ? bp_q.pop_front() : 0;
      end
      if (!RspVld) in_rsp = 1'b0;
      if (RspVld && bp_left > 0) begin
        RspRdy = 1'b0;
        bp_left--;
      end else begin
        RspRdy = 1'b1;
      end
    end
  end

  // Monitor: checks divider-side issue fields and upstream responses against the scoreboard.
  initial begin
    txn_t cur, t;
    logic prev_inv, prev_hs, have_cur;
    prev_inv = 1'b0; prev_hs = 1'b0; have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        prev_inv = 1'b0; prev_hs = 1'b0; have_cur = 1'b0;
      end else begin
        if (prev_hs) begin
          chk("reqrdy_after_rsp", 64'(ReqRdy), 1);
          chk("rspvld_single", 64'(RspVld), 0);
        end
        prev_hs = 1'b0;
        if (DivInVld) begin
          chk("invld_pulse", 64'(prev_inv), 0);
          if (iss_q.size() == 0) fail("issue_unexpected");
          else begin
            cur = iss_q.pop_front();
            have_cur = 1'b1;
            chk("div_opa", 64'(DivOpA), 64'(cur.a));
            chk("div_opb", 64'(DivOpB), 64'(cur.b));
            chk("div_op", 64'(DivOp), 64'(cur.op));
            chk("div_shift", 64'(DivShift), 64'(cur.sh));
            chk("div_iszero", 64'(DivZero), 64'(cur.z));
            chk("div_sign", 64'(DivSign), 64'(cur.s));
            chk("reqrdy_issue", 64'(ReqRdy), 0);
          end
        end
        prev_inv = DivInVld;
        if (DivOutRdy && have_cur) begin
          chk("wait_opa_hold", 64'(DivOpA), 64'(cur.a));
          chk("wait_shift_hold", 64'(DivShift), 64'(cur.sh));
          chk("reqrdy_wait", 64'(ReqRdy), 0);
        end
        if (RspVld) begin
          chk("outrdy_in_resp", 64'(DivOutRdy), 0);
          chk("reqrdy_in_resp", 64'(ReqRdy), 0);
          if (rsp_q.size() == 0) fail("rsp_unexpected");
          else begin
            t = rsp_q[0];
            chk("rsp_res", 64'(RspRes), 64'(t.res));
            chk("rsp_cycles", 64'(RspCycles), 64'(t.cyc));
            if (RspRdy) begin
              t = rsp_q.pop_front();
              prev_hs = 1'b1;
              have_cur = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a, b;
    rst_n = 1'b0; ReqVld = 1'b0; ReqA = '0; ReqB = '0; ReqOp = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_reqrdy", 64'(ReqRdy), 1);
    chk("rst_rspvld", 64'(RspVld), 0);
    chk("rst_invld", 64'(DivInVld), 0);
    chk("rst_outrdy", 64'(DivOutRdy), 0);
    chk("rst_rspres", 64'(RspRes), 0);
    chk("rst_rspcyc", 64'(RspCycles), 0);
    chk("rst_opa", 64'(DivOpA), 0);
    chk("rst_shift", 64'(DivShift), 0);

    // Directed cases, including divide by zero in all four opcodes.
    do_req(32'd100, 32'd7, 2'd0, 4, 0);
    do_req(32'd100, 32'd7, 2'd2, 2, 0);
    do_req(32'hFFFF_FFF9, 32'd2, 2'd3, 5, 0);
    do_req(32'hFFFF_FFF9, 32'd2, 2'd1, 1, 0);
    do_req(32'd5, 32'd0, 2'd0, 2, 0);
    do_req(32'd5, 32'd0, 2'd2, 2, 0);
    do_req(32'd5, 32'd0, 2'd1, 2, 0);
    do_req(32'd5, 32'd0, 2'd3, 2, 0);
    do_req(32'h8000_0000, 32'hFFFF_FFFF, 2'd1, 3, 0);
    // Backpressure, fixed three-cycle latency back to back, counter saturation.
    do_req(32'd1000, 32'd3, 2'd0, 6, 5);
    do_req(32'd77, 32'd5, 2'd0, 3, 0);
    do_req(32'd78, 32'd5, 2'd2, 3, 2);
    do_req(32'd12345, 32'd10, 2'd0, 300, 0);
    drain();

    // Reset in the middle of WAIT.
    do_req(32'd100, 32'd7, 2'd0, 50, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!DivOutRdy && n < 100);
    chk("reached_wait", 64'(DivOutRdy), 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    iss_q.delete(); rsp_q.delete(); lat_q.delete(); bp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_reqrdy", 64'(ReqRdy), 1);
    chk("midrst_rspvld", 64'(RspVld), 0);
    chk("midrst_invld", 64'(DivInVld), 0);
    chk("midrst_outrdy", 64'(DivOutRdy), 0);
    do_req(32'd100, 32'd7, 2'd0, 2, 0);
    drain();

    // Randomized traffic with edge-value divisors.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 1000);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        3: b = 32'h8000_0000;
        4: b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_req(a, b, 2'($urandom_range(0, 3)), $urandom_range(1, 12), $urandom_range(0, 3));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
